pcs_sync_multi: RTL and testbench

- Parametrised successor to the team's single-purpose 1000BASE-X receive synchronization block.
- Acquires and tracks code-group alignment per IEEE 802.3 Clause 36 (Figure 36-9).
- Thresholds are configurable: commas needed to acquire, errors tolerated, good code-groups needed to forgive one error. Adds signal_detect gating.
- Sits between the transmitter/PMA code-group stream and the receiver; it drives sync_status, rx_even, SUDI and x.

---
 rtl/pcs_sync_pkg.sv | 15 +
 rtl/cg_classify.sv | 22 ++
 rtl/pcs_sync_multi.sv | 193 +++++++++++++++++++
 tb/tb_pcs_sync_multi.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcs_sync_pkg.sv
// Shared types and constants for the 1000BASE-X receive synchronization block.
package pcs_sync_pkg;

    typedef enum logic [2:0] {
        LOSS      = 3'd0,
        COMMA_DET = 3'd1,
        ACQ       = 3'd2,
        SYNC_OK   = 3'd3,
        SYNC_ERR  = 3'd4
    } sync_state_e;

    localparam logic [6:0] COMMA_P = 7'b0011111;
    localparam logic [6:0] COMMA_N = 7'b1100000;

endpackage

// File: rtl/cg_classify.sv
// Combinational code-group classifier: comma / data / invalid.
module cg_classify
    import pcs_sync_pkg::*;
(
    input  logic [9:0] rx_code_group,
    input  logic       cg_valid,
    output logic       comma,
    output logic       data,
    output logic       invalid
);

    // Only the seven comma bits take part in classification.
    logic unused_low_bits;
    assign unused_low_bits = ^rx_code_group[2:0];

    always_comb begin
        comma   = (rx_code_group[9:3] == COMMA_P) || (rx_code_group[9:3] == COMMA_N);
        data    = cg_valid & ~comma;
        invalid = ~cg_valid;
    end

endmodule

// File: rtl/pcs_sync_multi.sv
// Parametrised 1000BASE-X receive code-group synchronization (Clause 36 style).
// Optional loss-event counter port is enabled with PCS_SYNC_STATS_EN.
module pcs_sync_multi
    import pcs_sync_pkg::*;
#(
    parameter int unsigned COMMAS_REQ = 3,
    parameter int unsigned ERR_LIMIT  = 3,
    parameter int unsigned GOOD_REQ   = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PUDI,
    input  logic [9:0]       rx_code_group,
    input  logic             cg_valid,
    input  logic             signal_detect,
    output logic [9:0]       x,
    output logic             SUDI,
    output logic             rx_even,
    output logic             sync_status
`ifdef PCS_SYNC_STATS_EN
    ,
    output logic [CNT_W-1:0] loss_events
`endif
);

    localparam logic [2:0] CommasReq = 3'(COMMAS_REQ);
    localparam logic [2:0] ErrLimit  = 3'(ERR_LIMIT);
    localparam logic [3:0] GoodReq   = 4'(GOOD_REQ);

    sync_state_e state_q, state_d;
    logic [2:0]  comma_cnt_q, comma_cnt_d;
    logic [2:0]  err_cnt_q, err_cnt_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic        rx_even_q, rx_even_d;
    logic [9:0]  x_q;
    logic        sudi_q;
    logic        sync_q;

    logic        comma, data, invalid;
    logic        sync_error;
    logic [2:0]  comma_inc;
    logic [3:0]  good_inc;

    cg_classify u_classify (
        .rx_code_group (rx_code_group),
        .cg_valid      (cg_valid),
        .comma         (comma),
        .data          (data),
        .invalid       (invalid)
    );

    // A comma arriving while rx_even is already 1 would land on an odd position.
    assign sync_error = invalid | (comma & rx_even_q);
    assign comma_inc  = (comma_cnt_q == 3'd7) ? 3'd7 : comma_cnt_q + 3'd1;
    assign good_inc   = good_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        err_cnt_d   = err_cnt_q;
        good_cnt_d  = good_cnt_q;
        rx_even_d   = rx_even_q;

        if (PUDI) begin
            if (!signal_detect) begin
                state_d     = LOSS;
                comma_cnt_d = '0;
                err_cnt_d   = '0;
                good_cnt_d  = '0;
                rx_even_d   = ~rx_even_q;
            end else begin
                unique case (state_q)
                    LOSS: begin
                        rx_even_d = ~rx_even_q;
                        if (comma) begin
                            state_d     = COMMA_DET;
                            rx_even_d   = 1'b1;
                            comma_cnt_d = comma_inc;
                        end
                    end
                    COMMA_DET: begin
                        rx_even_d = 1'b0;
                        if (data) begin
                            if (comma_cnt_q == CommasReq) begin
                                state_d    = SYNC_OK;
                                err_cnt_d  = '0;
                                good_cnt_d = '0;
                            end else begin
                                state_d = ACQ;
                            end
                        end else begin
                            state_d     = LOSS;
                            comma_cnt_d = '0;
                        end
                    end
                    ACQ: begin
                        rx_even_d = ~rx_even_q;
                        if (sync_error) begin
                            state_d     = LOSS;
                            comma_cnt_d = '0;
                        end else if (comma) begin
                            state_d     = COMMA_DET;
                            rx_even_d   = 1'b1;
                            comma_cnt_d = comma_inc;
                        end
                    end
                    SYNC_OK, SYNC_ERR: begin
                        rx_even_d = ~rx_even_q;
                        if (sync_error) begin
                            if (err_cnt_q >= ErrLimit) begin
                                state_d     = LOSS;
                                comma_cnt_d = '0;
                                err_cnt_d   = '0;
                                good_cnt_d  = '0;
                            end else begin
                                state_d    = SYNC_ERR;
                                err_cnt_d  = err_cnt_q + 3'd1;
                                good_cnt_d = '0;
                            end
                        end else if (state_q == SYNC_ERR) begin
                            if (good_inc >= GoodReq) begin
                                err_cnt_d  = err_cnt_q - 3'd1;
                                good_cnt_d = '0;
                                if (err_cnt_q == 3'd1) begin
                                    state_d = SYNC_OK;
                                end
                            end else begin
                                good_cnt_d = good_inc;
                            end
                        end
                    end
                    default: begin
                        state_d     = LOSS;
                        comma_cnt_d = '0;
                        err_cnt_d   = '0;
                        good_cnt_d  = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= LOSS;
            comma_cnt_q <= '0;
            err_cnt_q   <= '0;
            good_cnt_q  <= '0;
            rx_even_q   <= 1'b0;
            x_q         <= '0;
            sudi_q      <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            err_cnt_q   <= err_cnt_d;
            good_cnt_q  <= good_cnt_d;
            rx_even_q   <= rx_even_d;
            sudi_q      <= PUDI;
            sync_q      <= (state_d == SYNC_OK) || (state_d == SYNC_ERR);
            if (PUDI) begin
                x_q <= rx_code_group;
            end
        end
    end

    assign x           = x_q;
    assign SUDI        = sudi_q;
    assign rx_even     = rx_even_q;
    assign sync_status = sync_q;

`ifdef PCS_SYNC_STATS_EN
    logic [CNT_W-1:0] loss_q;
    logic             lost;

    assign lost = PUDI && (state_q == SYNC_OK || state_q == SYNC_ERR) && (state_d == LOSS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            loss_q <= '0;
        end else if (lost) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign loss_events = loss_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pcs_sync_multi.sv
// Randomised bench for pcs_sync_multi: default and (1,1,2) builds against a reference model.
module tb_pcs_sync_multi;

    localparam logic [9:0] K28_5 = 10'b0011111010;
    localparam logic [9:0] K28_5N = 10'b1100000101;
    localparam logic [9:0] D16_2 = 10'b1001000101;

    logic       clk;
    logic       rst;
    logic       PUDI;
    logic [9:0] rx_code_group;
    logic       cg_valid;
    logic       signal_detect;

    logic [9:0] x0, x1;
    logic       sudi0, sudi1, even0, even1, sync0, sync1;
`ifdef PCS_SYNC_STATS_EN
    logic [15:0] loss0, loss1;
`endif

    int n_checks = 0;
    int n_pass = 0;

    pcs_sync_multi u_dut0 (
        .clk           (clk),
        .rst           (rst),
        .PUDI          (PUDI),
        .rx_code_group (rx_code_group),
        .cg_valid      (cg_valid),
        .signal_detect (signal_detect),
        .x             (x0),
        .SUDI          (sudi0),
        .rx_even       (even0),
        .sync_status   (sync0)
`ifdef PCS_SYNC_STATS_EN
        ,
        .loss_events   (loss0)
`endif
    );

    pcs_sync_multi #(
        .COMMAS_REQ (1),
        .ERR_LIMIT  (1),
        .GOOD_REQ   (2)
    ) u_dut1 (
        .clk           (clk),
        .rst           (rst),
        .PUDI          (PUDI),
        .rx_code_group (rx_code_group),
        .cg_valid      (cg_valid),
        .signal_detect (signal_detect),
        .x             (x1),
        .SUDI          (sudi1),
        .rx_even       (even1),
        .sync_status   (sync1)
`ifdef PCS_SYNC_STATS_EN
        ,
        .loss_events   (loss1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. mode: 0 hunting, 1 just saw comma, 2 aligning, 3 locked.
    int         p_creq[2] = '{3, 1};
    int         p_elim[2] = '{3, 1};
    int         p_greq[2] = '{3, 2};
    int         m_mode[2], m_commas[2], m_errs[2], m_goods[2], m_losses[2];
    bit         m_even[2], m_known[2], m_sudi[2];
    logic [9:0] m_x[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit is_comma_ref(input logic [9:0] cg);
        logic [6:0] top;
        top = 7'(cg >> 3);
        return (top == 7'h1F) || (top == 7'h60);
    endfunction

    task automatic model_clear(input int k);
        m_mode[k]   = 0;
        m_commas[k] = 0;
        m_errs[k]   = 0;
        m_goods[k]  = 0;
    endtask

    task automatic model_edge(input int k);
        bit cm, odd_land, bad;
        if (!rst) begin
            model_clear(k);
            m_even[k] = 0; m_known[k] = 1; m_sudi[k] = 0; m_x[k] = '0; m_losses[k] = 0;
            return;
        end
        m_sudi[k] = PUDI;
        if (!PUDI) return;
        m_x[k] = rx_code_group;
        cm = is_comma_ref(rx_code_group);
        odd_land = m_even[k];
        bad = !cg_valid || (cm && odd_land);
        if (!signal_detect) begin
            if (m_mode[k] == 3) m_losses[k]++;
            model_clear(k);
            m_even[k] = ~m_even[k];
            m_known[k] = 0;
            return;
        end
        if (m_mode[k] == 1) m_even[k] = 0;
        else m_even[k] = ~m_even[k];
        if (m_mode[k] == 0) begin
            if (cm) begin
                m_mode[k] = 1; m_even[k] = 1; m_known[k] = 1;
                m_commas[k] = (m_commas[k] < 7) ? m_commas[k] + 1 : 7;
            end
        end else if (m_mode[k] == 1) begin
            if (cg_valid && !cm) begin
                if (m_commas[k] == p_creq[k]) begin
                    m_mode[k] = 3; m_errs[k] = 0; m_goods[k] = 0;
                end else m_mode[k] = 2;
            end else begin
                m_mode[k] = 0; m_commas[k] = 0;
            end
        end else if (m_mode[k] == 2) begin
            if (bad) begin
                m_mode[k] = 0; m_commas[k] = 0;
            end else if (cm) begin
                m_mode[k] = 1; m_even[k] = 1;
                m_commas[k] = (m_commas[k] < 7) ? m_commas[k] + 1 : 7;
            end
        end else begin
            if (bad) begin
                if (m_errs[k] + 1 > p_elim[k]) begin
                    model_clear(k);
                    m_losses[k]++;
                end else begin
                    m_errs[k]++; m_goods[k] = 0;
                end
            end else if (m_errs[k] > 0) begin
                m_goods[k]++;
                if (m_goods[k] == p_greq[k]) begin
                    m_errs[k]--; m_goods[k] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("d0.x", 32'(x0), 32'(m_x[0]));
        check("d0.sudi", 32'(sudi0), 32'(m_sudi[0]));
        check("d0.sync", 32'(sync0), 32'(m_mode[0] == 3));
        if (m_known[0]) check("d0.even", 32'(even0), 32'(m_even[0]));
        check("d1.x", 32'(x1), 32'(m_x[1]));
        check("d1.sudi", 32'(sudi1), 32'(m_sudi[1]));
        check("d1.sync", 32'(sync1), 32'(m_mode[1] == 3));
        if (m_known[1]) check("d1.even", 32'(even1), 32'(m_even[1]));
`ifdef PCS_SYNC_STATS_EN
        check("d0.loss", 32'(loss0), 32'(m_losses[0]) & 32'hFFFF);
        check("d1.loss", 32'(loss1), 32'(m_losses[1]) & 32'hFFFF);
`endif
    endtask

    task automatic cycle(input logic r, input logic p, input logic [9:0] cg, input logic v,
                         input logic s);
        @(negedge clk);
        rst = r; PUDI = p; rx_code_group = cg; cg_valid = v; signal_detect = s;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1 compare_all();
    endtask

    task automatic send(input logic [9:0] cg, input logic v);
        cycle(1'b1, 1'b1, cg, v, 1'b1);
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
        cycle(1'b0, 1'b1, K28_5, 1'b1, 1'b1);
    endtask

    task automatic idle_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            send(K28_5, 1'b1);
            send(D16_2, 1'b1);
        end
    endtask

    function automatic logic [9:0] rand_data();
        logic [9:0] c;
        c = 10'($urandom);
        if (is_comma_ref(c)) c ^= 10'h100;
        return c;
    endfunction

    initial begin
        bit         phase;
        int         r;
        logic       p, s, rr, v;
        logic [9:0] cg;

        rst = 1'b0; PUDI = 1'b0; rx_code_group = '0; cg_valid = 1'b1; signal_detect = 1'b1;
        do_reset();
        check("rst.sync0", 32'(sync0), 32'd0);
        check("rst.x0", 32'(x0), 32'd0);

        // Acquisition timing: d0 locks on the 3rd post-comma data, d1 on the 1st.
        send(K28_5, 1'b1);
        check("acq.even_on_comma", 32'(even0), 32'd1);
        send(D16_2, 1'b1);
        check("acq.d1_locked", 32'(sync1), 32'd1);
        send(K28_5, 1'b1);
        send(D16_2, 1'b1);
        send(K28_5, 1'b1);
        check("acq.d0_not_yet", 32'(sync0), 32'd0);
        send(D16_2, 1'b1);
        check("acq.d0_locked", 32'(sync0), 32'd1);

        // Odd-position comma during acquisition, then re-acquire.
        do_reset();
        send(K28_5, 1'b1);
        send(D16_2, 1'b1);
        send(D16_2, 1'b1);
        send(K28_5, 1'b1);
        check("parity.d0_lost", 32'(sync0), 32'd0);
        idle_pairs(4);
        check("parity.d0_reacq", 32'(sync0), 32'd1);

        // Error recovery: two invalid, six good.
        send(10'h155, 1'b0);
        send(10'h155, 1'b0);
        check("recov.d0_hold", 32'(sync0), 32'd1);
        idle_pairs(3);
        check("recov.d0_sync", 32'(sync0), 32'd1);

        // Four invalids back to back: loss on the fourth.
        for (int i = 0; i < 3; i++) send(10'h2AA, 1'b0);
        check("loss.d0_hold", 32'(sync0), 32'd1);
        send(10'h2AA, 1'b0);
        check("loss.d0_drop", 32'(sync0), 32'd0);

        // signal_detect gating, PUDI gaps, reset mid-acquisition.
        idle_pairs(5);
        cycle(1'b1, 1'b1, K28_5, 1'b1, 1'b0);
        check("sd.d0_drop", 32'(sync0), 32'd0);
        idle_pairs(5);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, D16_2, 1'b1, 1'b1);
        check("gap.sudi", 32'(sudi0), 32'd0);
        send(K28_5, 1'b1);
        send(D16_2, 1'b1);
        send(K28_5, 1'b1);
        cycle(1'b0, 1'b1, D16_2, 1'b1, 1'b1);
        check("rst.mid_even", 32'(even0), 32'd0);

        // Randomised stream around the idle pattern.
        phase = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            p = 1'b1; s = 1'b1; rr = 1'b1; v = 1'b1;
            cg = phase ? (($urandom_range(0, 1) == 0) ? K28_5 : K28_5N) : rand_data();
            if (r < 150) p = 1'b0;
            else if (r < 158) s = 1'b0;
            else if (r < 162) rr = 1'b0;
            else if (r < 212) begin
                cg = rand_data(); v = 1'b0; phase = ~phase;
            end else if (r < 235) cg = rand_data();
            else phase = ~phase;
            cycle(rr, p, cg, v, s);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
